hazard_ctrl_ms: RTL

- Next-generation pipeline hazard controller for the 5-stage RISC-V core.
- Detects load-use hazards from the IF/ID and ID/EX stages and inserts a configurable number of bubbles.
- Flushes the pipeline on a taken branch/JAL redirect, with optional extra IF/ID flush cycles for deeper fetch.
- Freezes the whole pipeline while the data memory is not ready.
- Holds multi-cycle stall/flush state in registers.

---
 rtl/hazard_ctrl_ms.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_ms.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_ms
//   Pipeline hazard controller for the 5-stage RISC-V core. Detects load-use
//   hazards between ID/EX and IF/ID and inserts LOAD_STALL_CYC bubbles,
//   flushes on a taken branch/JAL (plus FLUSH_CYC extra IF/ID clear cycles),
//   and freezes the pipeline while the data memory is busy.
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
//     defined   -> saturating stall/flush performance counters
//     undefined -> perf_* ports tied to zero, no counter flops
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_idex_memread/in_idex_rd    load in ID/EX and its destination
//   in_ifid_rs1/rs2, use_rs1/rs2  IF/ID sources and their use flags
//   in_branch_jal                 taken redirect resolved in EX
//   in_exmem_memacc/in_dmem_ready data memory access / completion
//   pcwrite, ifidwrite            PC and IF/ID write enables
//   controlsel                    1 = inject bubble into ID/EX
//   ifid_clear/idex_clear/exmem_clear  synchronous pipeline clears
//   pipe_hold                     1 = ID/EX, EX/MEM, MEM/WB hold
//   stall_active                  pcwrite=0 or sequence in progress
//   perf_stall_cnt/perf_flush_cnt performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl_ms #(
  parameter int RA_W           = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int FLUSH_CYC      = 0,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_idex_memread,
  input  logic [RA_W-1:0]  in_idex_rd,
  input  logic [RA_W-1:0]  in_ifid_rs1,
  input  logic [RA_W-1:0]  in_ifid_rs2,
  input  logic             in_ifid_use_rs1,
  input  logic             in_ifid_use_rs2,
  input  logic             in_branch_jal,
  input  logic             in_exmem_memacc,
  input  logic             in_dmem_ready,
  output logic             pcwrite,
  output logic             ifidwrite,
  output logic             controlsel,
  output logic             ifid_clear,
  output logic             idex_clear,
  output logic             exmem_clear,
  output logic             pipe_hold,
  output logic             stall_active,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  generate
    if (LOAD_STALL_CYC < 1 || LOAD_STALL_CYC > 15) begin : g_bad_ld
      $error("hazard_ctrl_ms: LOAD_STALL_CYC must be in 1..15");
    end
    if (FLUSH_CYC < 0 || FLUSH_CYC > 15) begin : g_bad_fl
      $error("hazard_ctrl_ms: FLUSH_CYC must be in 0..15");
    end
  endgenerate

  localparam logic [3:0] LD_INIT = 4'(LOAD_STALL_CYC - 1);
  localparam logic [3:0] FL_INIT = 4'(FLUSH_CYC);

  typedef enum logic [1:0] {S_RUN, S_LD_STALL, S_FLUSH} state_t;

  state_t     state;
  logic [3:0] cnt;

  logic hz_ld;
  logic mem_wait;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign hz_ld = in_idex_memread && (in_idex_rd != '0) &&
                 ((in_ifid_use_rs1 && (in_idex_rd == in_ifid_rs1)) ||
                  (in_ifid_use_rs2 && (in_idex_rd == in_ifid_rs2)));

  assign mem_wait = in_exmem_memacc && !in_dmem_ready;

  // Zero-latency control: outputs depend on current inputs and state.
  always_comb begin
    pcwrite     = 1'b1;
    ifidwrite   = 1'b1;
    controlsel  = 1'b0;
    ifid_clear  = 1'b0;
    idex_clear  = 1'b0;
    exmem_clear = 1'b0;
    pipe_hold   = 1'b0;
    if (rst) begin
      pcwrite     = 1'b0;
      ifidwrite   = 1'b0;
      controlsel  = 1'b1;
      ifid_clear  = 1'b1;
      idex_clear  = 1'b1;
      exmem_clear = 1'b1;
    end else if (mem_wait) begin
      pcwrite   = 1'b0;
      ifidwrite = 1'b0;
      pipe_hold = 1'b1;
    end else if (in_branch_jal) begin
      controlsel  = 1'b1;
      ifid_clear  = 1'b1;
      idex_clear  = 1'b1;
      exmem_clear = 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          if (hz_ld) begin
            pcwrite    = 1'b0;
            ifidwrite  = 1'b0;
            controlsel = 1'b1;
          end
        end
        S_LD_STALL: begin
          pcwrite    = 1'b0;
          ifidwrite  = 1'b0;
          controlsel = 1'b1;
        end
        S_FLUSH: begin
          ifid_clear = 1'b1;
          controlsel = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stall_active = rst || !pcwrite || (state != S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      cnt   <= 4'd0;
    end else if (mem_wait) begin
      // Memory busy: the whole sequence is frozen where it is.
      state <= state;
      cnt   <= cnt;
    end else if (in_branch_jal) begin
      // A redirect restarts the flush sequence regardless of what was running.
      if (FLUSH_CYC > 0) begin
        state <= S_FLUSH;
        cnt   <= FL_INIT;
      end else begin
        state <= S_RUN;
        cnt   <= 4'd0;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (hz_ld && (LOAD_STALL_CYC > 1)) begin
            state <= S_LD_STALL;
            cnt   <= LD_INIT;
          end
        end
        S_LD_STALL, S_FLUSH: begin
          if (cnt == 4'd1) begin
            state <= S_RUN;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= S_RUN;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (!pcwrite && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (ifid_clear && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign perf_stall_cnt = stall_cnt_reg;
  assign perf_flush_cnt = flush_cnt_reg;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
